// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the MIU arbiter.
// Optional feature macro used by the arbiter: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int ARB_ADDR_W      = 14;
  localparam int ARB_WDATA_W     = 16;
  localparam int ARB_RDATA_W     = 8;
  localparam int ARB_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_EX    = 1'b1
  } owner_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-cycle down-counter; expires after TIMEOUT_CYC enabled cycles since clear.
// Only compiled when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(TIMEOUT_CYC - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count reached on the last permitted BUSY cycle.
  assign expire_o = en_i && (cnt_q == '0);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing the MIU load/store port between fetch and execute.
// Define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | no MIU command, arbitrate requests
// BUSY  | MIU command held for the current owner
// DONE  | command dropped, owner done pulse
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int WDATA_W     = ARB_WDATA_W,
  parameter int RDATA_W     = ARB_RDATA_W,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_done,
  output logic [RDATA_W-1:0] fetch_data,
  input  logic               ex_load,
  input  logic               ex_store,
  input  logic [ADDR_W-1:0]  ex_addr,
  input  logic [WDATA_W-1:0] ex_wdata,
  output logic               ex_done,
  output logic [RDATA_W-1:0] ex_rdata,
  output logic               miu_load,
  output logic               miu_store,
  output logic [ADDR_W-1:0]  miu_addr,
  output logic [WDATA_W-1:0] miu_result,
  input  logic               miu_done,
  input  logic [RDATA_W-1:0] miu_data,
  output logic               arb_timeout
);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_owner_q, last_owner_d;
  op_e                op_q, op_d;
  logic               done_armed_q, done_armed_d;
  logic               miu_load_q, miu_load_d;
  logic               miu_store_q, miu_store_d;
  logic [ADDR_W-1:0]  miu_addr_q, miu_addr_d;
  logic [WDATA_W-1:0] miu_result_q, miu_result_d;
  logic               fetch_done_q, fetch_done_d;
  logic               ex_done_q, ex_done_d;
  logic [RDATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [RDATA_W-1:0] ex_rdata_q, ex_rdata_d;
  logic               timeout_q, timeout_d;

  logic ex_req;
  logic grant_fetch;
  logic done_seen;
  logic timer_clr;
  logic timer_expire;

  assign ex_req    = ex_load || ex_store;
  // A stale high done level from the previous op is ignored until it is seen low.
  assign done_seen = done_armed_q && miu_done;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (timer_clr),
    .en_i    (state_q == BUSY),
    .expire_o(timer_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0) ^ timer_clr;
  assign timer_expire       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    op_d         = op_q;
    done_armed_d = done_armed_q;
    miu_load_d   = miu_load_q;
    miu_store_d  = miu_store_q;
    miu_addr_d   = miu_addr_q;
    miu_result_d = miu_result_q;
    fetch_data_d = fetch_data_q;
    ex_rdata_d   = ex_rdata_q;
    fetch_done_d = 1'b0;
    ex_done_d    = 1'b0;
    timeout_d    = 1'b0;
    timer_clr    = 1'b0;
    grant_fetch  = fetch_req && (!ex_req || (last_owner_q == OWN_EX));

    case (state_q)
      IDLE: begin
        if (fetch_req || ex_req) begin
          state_d      = BUSY;
          done_armed_d = 1'b0;
          timer_clr    = 1'b1;
          if (grant_fetch) begin
            owner_d      = OWN_FETCH;
            op_d         = OP_LOAD;
            miu_load_d   = 1'b1;
            miu_store_d  = 1'b0;
            miu_addr_d   = fetch_addr;
            miu_result_d = '0;
          end else begin
            // Store wins when execute raises both load and store.
            owner_d      = OWN_EX;
            op_d         = ex_store ? OP_STORE : OP_LOAD;
            miu_load_d   = !ex_store;
            miu_store_d  = ex_store;
            miu_addr_d   = ex_addr;
            miu_result_d = ex_wdata;
          end
        end
      end

      BUSY: begin
        if (!miu_done) begin
          done_armed_d = 1'b1;
        end
        if (done_seen || timer_expire) begin
          state_d      = DONE;
          miu_load_d   = 1'b0;
          miu_store_d  = 1'b0;
          fetch_done_d = (owner_q == OWN_FETCH);
          ex_done_d    = (owner_q == OWN_EX);
          if (done_seen) begin
            if (op_q == OP_LOAD) begin
              if (owner_q == OWN_FETCH) begin
                fetch_data_d = miu_data;
              end else begin
                ex_rdata_d = miu_data;
              end
            end
          end else begin
            timeout_d = 1'b1;
            if (owner_q == OWN_FETCH) begin
              fetch_data_d = '0;
            end else begin
              ex_rdata_d = '0;
            end
          end
        end
      end

      DONE: begin
        state_d      = IDLE;
        last_owner_d = owner_q;
      end

      default: begin
        state_d     = IDLE;
        miu_load_d  = 1'b0;
        miu_store_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_EX;
      last_owner_q <= OWN_EX;
      op_q         <= OP_LOAD;
      done_armed_q <= 1'b0;
      miu_load_q   <= 1'b0;
      miu_store_q  <= 1'b0;
      miu_addr_q   <= '0;
      miu_result_q <= '0;
      fetch_data_q <= '0;
      ex_rdata_q   <= '0;
      fetch_done_q <= 1'b0;
      ex_done_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      op_q         <= op_d;
      done_armed_q <= done_armed_d;
      miu_load_q   <= miu_load_d;
      miu_store_q  <= miu_store_d;
      miu_addr_q   <= miu_addr_d;
      miu_result_q <= miu_result_d;
      fetch_data_q <= fetch_data_d;
      ex_rdata_q   <= ex_rdata_d;
      fetch_done_q <= fetch_done_d;
      ex_done_q    <= ex_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign miu_load    = miu_load_q;
  assign miu_store   = miu_store_q;
  assign miu_addr    = miu_addr_q;
  assign miu_result  = miu_result_q;
  assign fetch_done  = fetch_done_q;
  assign fetch_data  = fetch_data_q;
  assign ex_done     = ex_done_q;
  assign ex_rdata    = ex_rdata_q;
  assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [13:0] fetch_addr;
  logic        fetch_done;
  logic [7:0]  fetch_data;
  logic        ex_load;
  logic        ex_store;
  logic [13:0] ex_addr;
  logic [15:0] ex_wdata;
  logic        ex_done;
  logic [7:0]  ex_rdata;
  logic        miu_load;
  logic        miu_store;
  logic [13:0] miu_addr;
  logic [15:0] miu_result;
  logic        miu_done;
  logic [7:0]  miu_data;
  logic        arb_timeout;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_done (fetch_done),
    .fetch_data (fetch_data),
    .ex_load    (ex_load),
    .ex_store   (ex_store),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_done    (ex_done),
    .ex_rdata   (ex_rdata),
    .miu_load   (miu_load),
    .miu_store  (miu_store),
    .miu_addr   (miu_addr),
    .miu_result (miu_result),
    .miu_done   (miu_done),
    .miu_data   (miu_data),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    ex_load = 1'b0; ex_store = 1'b0; ex_addr = '0; ex_wdata = '0;
    miu_done = 1'b0; miu_data = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    ex_load = 1'b0; ex_store = 1'b0; ex_addr = '0; ex_wdata = '0;
    miu_done = 1'b0; miu_data = '0;
    #1;
    checks++;
    if ({fetch_done, ex_done, miu_load, miu_store, arb_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {fetch_done, ex_done, miu_load, miu_store, arb_timeout});
    end
    checks++;
    if ({miu_addr, miu_result, fetch_data, ex_rdata} !== 46'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {miu_addr, miu_result, fetch_data, ex_rdata});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({miu_load, miu_store} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req: got %b expected 00", {miu_load, miu_store});
    end
  endtask

  task automatic test_fetch_only();
    fetch_addr = 14'h0123; fetch_req = 1'b1; miu_done = 1'b0;
    tick();
    checks++;
    if ({miu_load, miu_store, miu_addr, ex_done} !== {1'b1, 1'b0, 14'h0123, 1'b0}) begin
      errors++;
      $display("FAIL fetch_grant: got ld=%b st=%b addr=%h exd=%b expected 1 0 0123 0", miu_load, miu_store, miu_addr, ex_done);
    end
    tick(); tick();
    miu_done = 1'b1; miu_data = 8'hA5;
    tick();
    checks++;
    if ({fetch_done, fetch_data, ex_done, miu_load} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_done: got fd=%b data=%h exd=%b ld=%b expected 1 a5 0 0", fetch_done, fetch_data, ex_done, miu_load);
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if ({fetch_done, fetch_data, ex_done} !== {1'b0, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL fetch_hold: got fd=%b data=%h exd=%b expected 0 a5 0", fetch_done, fetch_data, ex_done);
    end
  endtask

  task automatic test_simultaneous_stale();
    do_reset();
    fetch_addr = 14'h0040; ex_addr = 14'h3FFF; ex_wdata = 16'hBEEF;
    fetch_req = 1'b1; ex_store = 1'b1;
    tick();
    checks++;
    if ({miu_load, miu_store, miu_addr} !== {1'b1, 1'b0, 14'h0040}) begin
      errors++;
      $display("FAIL tie_fetch_first: got ld=%b st=%b addr=%h expected 1 0 0040", miu_load, miu_store, miu_addr);
    end
    tick();
    miu_done = 1'b1; miu_data = 8'h3C;
    tick();
    checks++;
    if ({fetch_done, fetch_data, ex_done} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL tie_fetch_done: got fd=%b data=%h exd=%b expected 1 3c 0", fetch_done, fetch_data, ex_done);
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if ({miu_load, miu_store, fetch_done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_gap: got %b expected 000", {miu_load, miu_store, fetch_done});
    end
    tick();
    checks++;
    if ({miu_store, miu_load, miu_addr, miu_result} !== {1'b1, 1'b0, 14'h3FFF, 16'hBEEF}) begin
      errors++;
      $display("FAIL ex_store_grant: got st=%b ld=%b addr=%h res=%h expected 1 0 3fff beef", miu_store, miu_load, miu_addr, miu_result);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ex_done, miu_store} !== 2'b01) begin
        errors++;
        $display("FAIL stale_done_ignored: got exd=%b st=%b expected 0 1", ex_done, miu_store);
      end
    end
    miu_done = 1'b0;
    tick();
    miu_done = 1'b1; miu_data = 8'hEE;
    tick();
    checks++;
    if ({ex_done, fetch_done, miu_store, ex_rdata, arb_timeout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL ex_store_done: got exd=%b fd=%b st=%b rdata=%h to=%b expected 1 0 0 00 0", ex_done, fetch_done, miu_store, ex_rdata, arb_timeout);
    end
    ex_store = 1'b0;
    tick();
  endtask

  task automatic test_load_store_both();
    ex_addr = 14'h0055; ex_load = 1'b1;
    tick();
    checks++;
    if ({miu_load, miu_store} !== 2'b10) begin
      errors++;
      $display("FAIL ex_load_grant: got ld/st=%b expected 10", {miu_load, miu_store});
    end
    miu_done = 1'b0;
    tick();
    miu_done = 1'b1; miu_data = 8'h5A;
    tick();
    checks++;
    if ({ex_done, ex_rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL ex_load_done: got exd=%b rdata=%h expected 1 5a", ex_done, ex_rdata);
    end
    ex_load = 1'b0;
    tick();
    ex_load = 1'b1; ex_store = 1'b1; ex_wdata = 16'h1234;
    tick();
    checks++;
    if ({miu_load, miu_store, miu_result} !== {1'b0, 1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL both_is_store: got ld=%b st=%b res=%h expected 0 1 1234", miu_load, miu_store, miu_result);
    end
    miu_done = 1'b0;
    tick();
    miu_done = 1'b1; miu_data = 8'hFF;
    tick();
    checks++;
    if ({ex_done, ex_rdata} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL both_rdata_kept: got exd=%b rdata=%h expected 1 5a", ex_done, ex_rdata);
    end
    ex_load = 1'b0; ex_store = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic        exp_fetch;
    logic [13:0] exp_addr;
    logic [7:0]  dval;
    fetch_addr = 14'h0100; ex_addr = 14'h0200;
    fetch_req = 1'b1; ex_load = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_fetch = ((t % 2) == 0);
      exp_addr  = exp_fetch ? 14'h0100 : 14'h0200;
      dval      = 8'h10 + 8'(t);
      tick();
      checks++;
      if ({miu_load, miu_addr} !== {1'b1, exp_addr}) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got ld=%b addr=%h expected 1 %h", t, miu_load, miu_addr, exp_addr);
      end
      miu_done = 1'b0;
      tick();
      miu_done = 1'b1; miu_data = dval;
      tick();
      checks++;
      if ({fetch_done, ex_done} !== {exp_fetch, !exp_fetch} ||
          (exp_fetch ? fetch_data : ex_rdata) !== dval) begin
        errors++;
        $display("FAIL b2b_done[%0d]: got fd=%b exd=%b fdata=%h exdata=%h expected fd=%b data=%h",
                 t, fetch_done, ex_done, fetch_data, ex_rdata, exp_fetch, dval);
      end
      if (t == 3) begin
        fetch_req = 1'b0; ex_load = 1'b0;
      end else if (exp_fetch) begin
        fetch_req = 1'b0;
      end else begin
        ex_load = 1'b0;
      end
      tick();
      checks++;
      if ({miu_load, miu_store} !== 2'b00) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: got ld/st=%b expected 00", t, {miu_load, miu_store});
      end
      if (t != 3) begin
        fetch_req = 1'b1; ex_load = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    fetch_addr = 14'h0BBB; fetch_req = 1'b1; miu_done = 1'b0;
    tick();
    tick();
    miu_done = 1'b1; miu_data = 8'h42;
    tick();
    fetch_req = 1'b0;
    tick();
    fetch_req = 1'b1; ex_store = 1'b1; ex_addr = 14'h0AAA; ex_wdata = 16'h5555; miu_done = 1'b0;
    tick();
    checks++;
    if ({miu_store, miu_load, miu_addr} !== {1'b1, 1'b0, 14'h0AAA}) begin
      errors++;
      $display("FAIL rr_ex_wins: got st=%b ld=%b addr=%h expected 1 0 0aaa", miu_store, miu_load, miu_addr);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({miu_load, miu_store, fetch_done, ex_done, arb_timeout, miu_addr, miu_result, fetch_data} !== 43'h0) begin
      errors++;
      $display("FAIL async_reset: got ld=%b st=%b fd=%b exd=%b addr=%h res=%h fdata=%h expected all 0",
               miu_load, miu_store, fetch_done, ex_done, miu_addr, miu_result, fetch_data);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({miu_load, miu_store, miu_addr} !== {1'b1, 1'b0, 14'h0BBB}) begin
      errors++;
      $display("FAIL post_reset_fetch_wins: got ld=%b st=%b addr=%h expected 1 0 0bbb", miu_load, miu_store, miu_addr);
    end
    tick();
    miu_done = 1'b1; miu_data = 8'h99;
    tick();
    checks++;
    if ({fetch_done, ex_done, fetch_data} !== {1'b1, 1'b0, 8'h99}) begin
      errors++;
      $display("FAIL post_reset_done: got fd=%b exd=%b data=%h expected 1 0 99", fetch_done, ex_done, fetch_data);
    end
    fetch_req = 1'b0;
    tick();
    tick();
    miu_done = 1'b0;
    tick();
    miu_done = 1'b1;
    tick();
    checks++;
    if ({ex_done, fetch_done} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_ex_done: got exd=%b fd=%b expected 1 0", ex_done, fetch_done);
    end
    ex_store = 1'b0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    ex_addr = 14'h0010; ex_load = 1'b1; miu_done = 1'b0;
    tick();
    tick();
    miu_done = 1'b1; miu_data = 8'h77;
    tick();
    checks++;
    if ({ex_done, ex_rdata, arb_timeout} !== {1'b1, 8'h77, 1'b0}) begin
      errors++;
      $display("FAIL pre_timeout_load: got exd=%b rdata=%h to=%b expected 1 77 0", ex_done, ex_rdata, arb_timeout);
    end
    ex_load = 1'b0; miu_done = 1'b0;
    tick();
    ex_load = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({miu_load, ex_done, arb_timeout} !== 3'b100) begin
        errors++;
        $display("FAIL timeout_busy[%0d]: got ld=%b exd=%b to=%b expected 1 0 0", i, miu_load, ex_done, arb_timeout);
      end
      tick();
    end
    checks++;
    if ({ex_done, arb_timeout, ex_rdata, miu_load} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL timeout_abort: got exd=%b to=%b rdata=%h ld=%b expected 1 1 00 0", ex_done, arb_timeout, ex_rdata, miu_load);
    end
    ex_load = 1'b0;
    tick();
    checks++;
    if ({ex_done, arb_timeout} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse_width: got exd=%b to=%b expected 0 0", ex_done, arb_timeout);
    end
  endtask
`else
  task automatic test_no_timeout();
    ex_addr = 14'h0010; ex_load = 1'b1; miu_done = 1'b0;
    tick();
    for (int i = 0; i < 80; i++) begin
      checks++;
      if ({miu_load, ex_done, arb_timeout} !== 3'b100) begin
        errors++;
        $display("FAIL long_busy[%0d]: got ld=%b exd=%b to=%b expected 1 0 0", i, miu_load, ex_done, arb_timeout);
      end
      tick();
    end
    miu_done = 1'b1; miu_data = 8'h66;
    tick();
    checks++;
    if ({ex_done, ex_rdata, arb_timeout, miu_load} !== {1'b1, 8'h66, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL long_busy_done: got exd=%b rdata=%h to=%b ld=%b expected 1 66 0 0", ex_done, ex_rdata, arb_timeout, miu_load);
    end
    ex_load = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous_stale();
    test_load_store_both();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
